// File: rtl/config_pkg.sv
// Build-time sizing knobs shared across the core.
// Holds the default LSU request buffer depth.
package config_pkg;

    localparam int unsigned LSU_BUF_DEPTH = 4;

endpackage

// File: rtl/lsu_pkg.sv
// Shared LSU types used by the pipeline and its buffers.
// lsu_ctrl_t is the request record handed to the LSU.
package lsu_pkg;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
    } lsu_ctrl_t;

endpackage

// File: rtl/lsu_req_buffer.sv
// Circular request buffer in front of the LSU, with a bypass when empty.
// Ports: clk_i, rst_i (async, active-high), flush_i, lsu_req_i,
//   lsu_req_valid_i, pop_ld_i, pop_st_i -> lsu_ctrl_o, ready_o,
//   count_o, full_o, overflow_o, underflow_o.
module lsu_req_buffer
    import config_pkg::*;
#(
    parameter int unsigned DEPTH        = LSU_BUF_DEPTH,
    parameter type         lsu_ctrl_t   = lsu_pkg::lsu_ctrl_t,
    parameter bit          STRICT_READY = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  lsu_ctrl_t                  lsu_req_i,
    input  logic                       lsu_req_valid_i,
    input  logic                       pop_ld_i,
    input  logic                       pop_st_i,
    output lsu_ctrl_t                  lsu_ctrl_o,
    output logic                       ready_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int unsigned   PW       = $clog2(DEPTH);
    localparam int unsigned   CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    lsu_ctrl_t     mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          underflow_q;

    logic [1:0]    pops_req;
    logic [1:0]    pops;
    logic          push_ok;
    logic          underflow_n;

    // Pops are clipped to occupancy; a pop frees a slot for a push
    // in the same cycle, so a full buffer still accepts push+pop.
    always_comb begin
        pops_req    = {1'b0, pop_ld_i} + {1'b0, pop_st_i};
        underflow_n = CW'(pops_req) > count_q;
        pops        = underflow_n ? count_q[1:0] : pops_req;
        push_ok     = lsu_req_valid_i
                    && ((count_q != FULL_CNT) || (pops != 2'd0));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q       <= '{default: '0};
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flush_i) begin
            mem_q       <= '{default: '0};
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            // Retired slots lose valid; a push landing on the same
            // slot (full buffer) is written last and wins.
            if (pops != 2'd0) begin
                mem_q[rd_ptr_q].valid <= 1'b0;
            end
            if (pops == 2'd2) begin
                mem_q[rd_ptr_q + PW'(1)].valid <= 1'b0;
            end
            if (push_ok) begin
                mem_q[wr_ptr_q] <= lsu_req_i;
            end
            rd_ptr_q    <= rd_ptr_q + PW'(pops);
            wr_ptr_q    <= wr_ptr_q + PW'(push_ok);
            count_q     <= count_q + CW'(push_ok) - CW'(pops);
            overflow_q  <= lsu_req_valid_i && !push_ok;
            underflow_q <= underflow_n;
        end
    end

    // Empty buffer forwards the incoming request with zero latency.
    assign lsu_ctrl_o  = (count_q == '0) ? lsu_req_i : mem_q[rd_ptr_q];
    assign full_o      = count_q == FULL_CNT;
    assign ready_o     = STRICT_READY ? (count_q == '0) : !full_o;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_lsu_req_buffer.sv
// Self-checking bench for lsu_req_buffer: directed vector table,
// hand sequences for reset/ready corners, and random vs. queue model.
module tb_lsu_req_buffer;
    import lsu_pkg::*;

    logic      clk_i;
    logic      rst_i;
    logic      flush_i;
    lsu_ctrl_t lsu_req_i;
    logic      lsu_req_valid_i;
    logic      pop_ld_i;
    logic      pop_st_i;

    lsu_ctrl_t   ctrl4, ctrl2;
    logic        rdy4, rdy2;
    logic [2:0]  cnt4;
    logic [1:0]  cnt2;
    logic        full4, full2;
    logic        ovf4, ovf2;
    logic        udf4, udf2;

    lsu_req_buffer #(
        .DEPTH(4), .lsu_ctrl_t(lsu_ctrl_t), .STRICT_READY(1'b1)
    ) u_dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .lsu_req_i(lsu_req_i), .lsu_req_valid_i(lsu_req_valid_i),
        .pop_ld_i(pop_ld_i), .pop_st_i(pop_st_i),
        .lsu_ctrl_o(ctrl4), .ready_o(rdy4), .count_o(cnt4),
        .full_o(full4), .overflow_o(ovf4), .underflow_o(udf4)
    );

    lsu_req_buffer #(
        .DEPTH(2), .lsu_ctrl_t(lsu_ctrl_t), .STRICT_READY(1'b0)
    ) u_dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .lsu_req_i(lsu_req_i), .lsu_req_valid_i(lsu_req_valid_i),
        .pop_ld_i(pop_ld_i), .pop_st_i(pop_st_i),
        .lsu_ctrl_o(ctrl2), .ready_o(rdy2), .count_o(cnt2),
        .full_o(full2), .overflow_o(ovf2), .underflow_o(udf2)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain FIFO queues plus expected pulse flags.
    lsu_ctrl_t q4[$];
    lsu_ctrl_t q2[$];
    bit eov4, euf4, eov2, euf2;

    typedef struct {
        bit        fl;
        bit        vld;
        bit        pld;
        bit        pst;
        lsu_ctrl_t req;
        int        cnt;
        lsu_ctrl_t ctrl;
        bit        rdy;
        bit        full;
        bit        ov;
        bit        uf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic lsu_ctrl_t mk(logic [31:0] a);
        lsu_ctrl_t r;
        r.valid = 1'b1;
        r.we    = a[8];
        r.size  = 2'd2;
        r.addr  = a;
        return r;
    endfunction

    task automatic model_clear();
        q4.delete();
        q2.delete();
        eov4 = 0; euf4 = 0;
        eov2 = 0; euf2 = 0;
    endtask

    task automatic model_step(input int which);
        lsu_ctrl_t q[$];
        int depth, preq, pops;
        bit acc, ov, uf;
        if (which == 0) begin q = q4; depth = 4; end
        else begin q = q2; depth = 2; end
        ov = 0;
        uf = 0;
        if (flush_i) begin
            q.delete();
        end else begin
            preq = int'(pop_ld_i) + int'(pop_st_i);
            pops = (preq < q.size()) ? preq : q.size();
            uf   = preq > q.size();
            acc  = lsu_req_valid_i && (q.size() < depth || pops > 0);
            ov   = lsu_req_valid_i && !acc;
            repeat (pops) void'(q.pop_front());
            if (acc) q.push_back(lsu_req_i);
        end
        if (which == 0) begin q4 = q; eov4 = ov; euf4 = uf; end
        else begin q2 = q; eov2 = ov; euf2 = uf; end
    endtask

    task automatic check_dut(input int which);
        lsu_ctrl_t q[$];
        lsu_ctrl_t exp_ctrl;
        int depth;
        bit strict, eov, euf;
        string t;
        if (which == 0) begin
            q = q4; depth = 4; strict = 1; eov = eov4; euf = euf4; t = "d4";
        end else begin
            q = q2; depth = 2; strict = 0; eov = eov2; euf = euf2; t = "d2";
        end
        exp_ctrl = (q.size() == 0) ? lsu_req_i : q[0];
        if (which == 0) begin
            chk({t, ".ctrl"}, 64'(ctrl4), 64'(exp_ctrl));
            chk({t, ".count"}, 64'(cnt4), 64'(q.size()));
            chk({t, ".full"}, 64'(full4), 64'(q.size() == depth));
            chk({t, ".ready"}, 64'(rdy4), 64'(q.size() == 0));
            chk({t, ".ovf"}, 64'(ovf4), 64'(eov));
            chk({t, ".udf"}, 64'(udf4), 64'(euf));
        end else begin
            chk({t, ".ctrl"}, 64'(ctrl2), 64'(exp_ctrl));
            chk({t, ".count"}, 64'(cnt2), 64'(q.size()));
            chk({t, ".full"}, 64'(full2), 64'(q.size() == depth));
            chk({t, ".ready"}, 64'(rdy2),
                64'(strict ? q.size() == 0 : q.size() < depth));
            chk({t, ".ovf"}, 64'(ovf2), 64'(eov));
            chk({t, ".udf"}, 64'(udf2), 64'(euf));
        end
    endtask

    // Inputs are driven 1ns after the rising edge; outputs are
    // sampled 4ns after it, well clear of either clock edge.
    task automatic settle();
        #3;
        check_dut(0);
        check_dut(1);
        model_step(0);
        model_step(1);
    endtask

    task automatic advance();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(bit fl, bit v, bit pl, bit ps, lsu_ctrl_t r);
        flush_i         = fl;
        lsu_req_valid_i = v;
        pop_ld_i        = pl;
        pop_st_i        = ps;
        lsu_req_i       = r;
    endtask

    task automatic add(bit fl, bit v, bit pl, bit ps, lsu_ctrl_t r,
                       int c, lsu_ctrl_t x, bit rd, bit fu, bit ov, bit uf);
        vec_t e;
        e.fl = fl; e.vld = v; e.pld = pl; e.pst = ps; e.req = r;
        e.cnt = c; e.ctrl = x; e.rdy = rd; e.full = fu;
        e.ov = ov; e.uf = uf;
        tbl.push_back(e);
    endtask

    task automatic check_reset_outputs(string t);
        chk({t, ".count4"}, 64'(cnt4), 64'(0));
        chk({t, ".full4"}, 64'(full4), 64'(0));
        chk({t, ".ovf4"}, 64'(ovf4), 64'(0));
        chk({t, ".udf4"}, 64'(udf4), 64'(0));
        chk({t, ".ready4"}, 64'(rdy4), 64'(1));
        chk({t, ".ctrl4"}, 64'(ctrl4), 64'(lsu_req_i));
        chk({t, ".count2"}, 64'(cnt2), 64'(0));
        chk({t, ".ready2"}, 64'(rdy2), 64'(1));
    endtask

    lsu_ctrl_t A, B, C, D, E, F, G, H, I, J, K, Z;

    initial begin
        A = mk(32'h100); B = mk(32'h200); C = mk(32'h300);
        D = mk(32'h400); E = mk(32'h500); F = mk(32'h600);
        G = mk(32'h700); H = mk(32'h800); I = mk(32'h900);
        J = mk(32'hA00); K = mk(32'hB00); Z = '0;

        //    fl v pl ps req | cnt ctrl rdy full ov uf
        add(0, 1, 0, 0, A,   0, A, 1, 0, 0, 0);
        add(0, 0, 0, 0, Z,   1, A, 0, 0, 0, 0);
        add(0, 1, 0, 0, B,   1, A, 0, 0, 0, 0);
        add(0, 1, 0, 0, C,   2, A, 0, 0, 0, 0);
        add(0, 1, 0, 0, D,   3, A, 0, 0, 0, 0);
        add(0, 1, 0, 0, E,   4, A, 0, 1, 0, 0);
        add(0, 0, 0, 0, Z,   4, A, 0, 1, 1, 0);
        add(0, 0, 0, 0, Z,   4, A, 0, 1, 0, 0);
        add(0, 0, 1, 0, Z,   4, A, 0, 1, 0, 0);
        add(0, 0, 1, 1, Z,   3, B, 0, 0, 0, 0);
        add(0, 0, 1, 1, Z,   1, D, 0, 0, 0, 0);
        add(0, 0, 0, 0, Z,   0, Z, 1, 0, 0, 1);
        add(0, 0, 0, 0, Z,   0, Z, 1, 0, 0, 0);
        add(0, 1, 0, 0, F,   0, F, 1, 0, 0, 0);
        add(0, 1, 0, 0, G,   1, F, 0, 0, 0, 0);
        add(0, 1, 0, 0, H,   2, F, 0, 0, 0, 0);
        add(0, 1, 0, 0, I,   3, F, 0, 0, 0, 0);
        add(0, 1, 0, 1, J,   4, F, 0, 1, 0, 0);
        add(0, 1, 1, 0, K,   4, G, 0, 1, 0, 0);
        add(0, 0, 0, 0, Z,   4, H, 0, 1, 0, 0);
        add(0, 0, 1, 1, Z,   4, H, 0, 1, 0, 0);
        add(0, 0, 1, 1, Z,   2, J, 0, 0, 0, 0);
        add(0, 0, 0, 0, Z,   0, Z, 1, 0, 0, 0);
        add(0, 1, 0, 0, A,   0, A, 1, 0, 0, 0);
        add(0, 1, 0, 0, B,   1, A, 0, 0, 0, 0);
        add(0, 1, 0, 0, C,   2, A, 0, 0, 0, 0);
        add(1, 1, 1, 0, D,   3, A, 0, 0, 0, 0);
        add(0, 0, 0, 0, Z,   0, Z, 1, 0, 0, 0);
        add(1, 1, 1, 1, E,   0, E, 1, 0, 0, 0);
        add(0, 0, 0, 0, Z,   0, Z, 1, 0, 0, 0);
        add(0, 1, 0, 0, A,   0, A, 1, 0, 0, 0);
        add(0, 1, 0, 0, B,   1, A, 0, 0, 0, 0);
        add(0, 1, 0, 0, C,   2, A, 0, 0, 0, 0);
        add(0, 1, 0, 0, D,   3, A, 0, 0, 0, 0);
        add(1, 1, 0, 0, E,   4, A, 0, 1, 0, 0);
        add(0, 0, 0, 0, Z,   0, Z, 1, 0, 0, 0);

        // Reset: outputs must already be at reset values.
        rst_i = 1'b1;
        drive(0, 0, 0, 0, mk(32'hDEAD0000));
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("por");
        rst_i = 1'b0;
        model_clear();

        foreach (tbl[k]) begin
            drive(tbl[k].fl, tbl[k].vld, tbl[k].pld, tbl[k].pst,
                  tbl[k].req);
            settle();
            chk($sformatf("vec%0d.ctrl", k), 64'(ctrl4), 64'(tbl[k].ctrl));
            chk($sformatf("vec%0d.count", k), 64'(cnt4), 64'(tbl[k].cnt));
            chk($sformatf("vec%0d.ready", k), 64'(rdy4), 64'(tbl[k].rdy));
            chk($sformatf("vec%0d.full", k), 64'(full4), 64'(tbl[k].full));
            chk($sformatf("vec%0d.ovf", k), 64'(ovf4), 64'(tbl[k].ov));
            chk($sformatf("vec%0d.udf", k), 64'(udf4), 64'(tbl[k].uf));
            advance();
        end

        // DEPTH=2 non-strict ready across occupancy 0, 1, 2.
        drive(0, 1, 0, 0, A);
        settle();
        chk("d2rdy.cnt0", 64'(rdy2), 64'(1));
        advance();
        drive(0, 1, 0, 0, B);
        settle();
        chk("d2rdy.cnt1", 64'(rdy2), 64'(1));
        advance();
        drive(0, 0, 0, 0, Z);
        settle();
        chk("d2rdy.cnt2", 64'(rdy2), 64'(0));
        chk("d2rdy.full", 64'(full2), 64'(1));
        advance();

        // Reset mid-stream while a push and pop are requested.
        drive(0, 1, 0, 0, C);
        settle();
        advance();
        drive(0, 1, 1, 0, mk(32'hBEEF0000));
        #1;
        rst_i = 1'b1;
        #1;
        check_reset_outputs("midrst");
        advance();
        check_reset_outputs("midrst_hold");
        rst_i = 1'b0;
        model_clear();
        drive(0, 0, 0, 0, Z);
        settle();
        advance();

        // Random traffic against the queue model.
        for (int n = 0; n < 600; n++) begin
            lsu_ctrl_t r;
            r = lsu_ctrl_t'({$urandom, $urandom});
            drive($urandom_range(0, 49) == 0,
                  $urandom_range(0, 99) < 60,
                  $urandom_range(0, 99) < 28,
                  $urandom_range(0, 99) < 28,
                  r);
            settle();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
